map_table: RTL and testbench
============================

MAP_TABLE -- requirements
Module: map_table

Interface
REQ-001 The block SHALL have the parameter NUM_ARCH_REG, default 32, giving the number of architectural registers.
REQ-002 The block SHALL have the parameter TAG_W, default 4, giving the ROB-tag width; tag 0 means "value in register file".
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- rs1_idx  in  5  source-1 architectural index from decode.
- rs2_idx  in  5  source-2 architectural index from decode.
- rename_en  in  1  dispatch this cycle.
- dest_idx  in  5  destination architectural index.
- rob_entry  in  TAG_W  ROB tag of the dispatched instruction (never 0).
- cdb_tag  in  TAG_W  completing tag; 0 = no broadcast.
- retire_en  in  1  ROB head commits.
- retire_idx  in  5  committed architectural destination.
- retire_tag  in  TAG_W  committed ROB tag.
- squash  in  1  flush all mappings.
- mt2rs_packet_out  out  struct  {rs1_tag, rs2_tag, rs1_ready, rs2_ready} to the RS entry.

Function
REQ-004 Per register, the table SHALL hold a tag (TAG_W bits) and a ready bit.
REQ-005 Source lookup SHALL be combinational, with zero latency: rsN_tag = table[rsN_idx].tag and rsN_ready = table[rsN_idx].ready.
REQ-006 A source with a tag of 0 SHALL output tag 0 and ready 0, so the RS reads the register file value.
REQ-007 Lookup SHALL use pre-edge state: sources SHALL see the old mapping, even when dest_idx equals rsN_idx in the same cycle.
REQ-008 On a rising edge with rename_en=1 and dest_idx!=0, the block SHALL write table[dest_idx] <= {rob_entry, ready=0}.
REQ-009 Register 0 SHALL never be renamed, and its tag SHALL stay 0.
REQ-010 On a rising edge with cdb_tag!=0, every row whose tag equals cdb_tag SHALL set ready <= 1.
REQ-011 On a rising edge with retire_en=1, if table[retire_idx].tag == retire_tag, the row SHALL clear to {0, 0}; otherwise it SHALL be unchanged, because it has been re-renamed.
REQ-012 On squash=1, every row SHALL clear to {0, 0} at the edge; squash SHALL override rename, CDB and retire in the same cycle.
REQ-013 When rename and retire target the same row in the same cycle, rename SHALL win.
REQ-014 When rename and CDB target the same row in the same cycle, rename SHALL win, leaving ready=0 for the new tag.
REQ-015 When retire and CDB target the same row in the same cycle, retire SHALL win, clearing the row.

Reset
REQ-016 While reset=0, all rows SHALL be {tag 0, ready 0} immediately, with no clock required.
REQ-017 While reset=0, mt2rs_packet_out SHALL therefore read all zeros.
REQ-018 Reset asserted mid-operation SHALL discard all mappings.
REQ-019 Inputs during reset SHALL be ignored.

Configuration
REQ-020 The block SHALL support the macro MT_CDB_BYPASS_EN.
REQ-021 With MT_CDB_BYPASS_EN defined, when cdb_tag!=0 and matches the looked-up nonzero tag, rsN_ready SHALL be forced to 1 combinationally in the same cycle.
REQ-022 Without MT_CDB_BYPASS_EN, ready SHALL become visible one cycle after the broadcast; the RS entry captures the CDB itself.

Structure
REQ-023 MT2RS_PACKET, a MT_ROW typedef {tag, ready}, and the NUM_ARCH_REG / TAG_W constants SHALL be defined in the shared package.
REQ-024 The block SHALL be a single module with no sub-module; the row array and next-state logic SHALL be implemented inside it.
REQ-025 Implementation size SHALL be about 150 lines.

Verification
REQ-026 Reset scenario: assert reset=0 mid-cycle with r5 mapped -> immediately all outputs 0; after reset release, rs1_idx=5 -> tag 0, ready 0.
REQ-027 Rename then lookup scenario: rename r3 -> tag 2; next cycle rs1_idx=3, rs2_idx=3 -> tags 2/2, ready 0/0; in the same cycle as the rename, rs1_idx=3 -> tag 0.
REQ-028 CDB scenario: r3 -> tag 2, then cdb_tag=2 -> next cycle ready=1, tag 2. With MT_CDB_BYPASS_EN, ready=1 SHALL be seen in the broadcast cycle itself.
REQ-029 Retire scenario:
- r4 -> tag 3, then r4 -> tag 5; retire (r4, tag 3) -> r4 stays tag 5.
- Retire (r4, tag 5) -> r4 tag 0.
REQ-030 Collision scenarios:
- Same cycle rename r6 -> tag 7 and retire (r6, old tag 1) -> tag 7, ready 0.
- Rename r1 -> tag 4 with cdb_tag=4 -> ready 0.
- rename_en with dest_idx=0 -> r0 tag 0.
REQ-031 Squash scenario: map r1..r3 to tags 1..3, then squash together with rename r7 -> tag 6 -> all rows 0, r7 tag 0.

Source files
------------

// File: rtl/map_table_pkg.sv
// map_table_pkg -- shared types and constants for the rename map table.
//
// Contents:
//   NUM_ARCH_REG  number of architectural registers (default table depth)
//   TAG_W         ROB-tag width; tag 0 means "value lives in the register file"
//   IDX_W         architectural index width used on the decode/retire ports
//   MT_ROW        one table row {tag, ready}
//   MT2RS_PACKET  lookup result sent to a reservation-station entry
//   mt_tag_hit    true when a nonzero broadcast tag matches a row tag
//
// The packet and row widths follow the package TAG_W. A map_table instance
// overriding its TAG_W parameter must keep it equal to this constant.

package map_table_pkg;

    localparam int unsigned NUM_ARCH_REG = 32;
    localparam int unsigned TAG_W        = 4;
    localparam int unsigned IDX_W        = 5;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             ready;
    } MT_ROW;

    typedef struct packed {
        logic [TAG_W-1:0] rs1_tag;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs1_ready;
        logic             rs2_ready;
    } MT2RS_PACKET;

    // Tag 0 is never broadcast, so a zero bus tag must not match empty rows.
    function automatic logic mt_tag_hit(input logic [TAG_W-1:0] row_tag,
                                        input logic [TAG_W-1:0] bus_tag);
        return (bus_tag != '0) && (bus_tag == row_tag);
    endfunction

endpackage

// File: rtl/map_table.sv
// map_table -- register rename map table.
//
// One row per architectural register holding the ROB tag of the youngest
// in-flight producer and a ready bit set when that producer broadcasts on the
// CDB. Source lookups are combinational from the registered table, so a
// rename in the same cycle is not visible to the sources of that cycle.
//
// Update priority per row at the clock edge:
//   squash > rename > retire (tag match only) > CDB ready set
// Row 0 is hardwired to {0, 0}.
//
// Build option:
//   MT_CDB_BYPASS_EN  when defined, a source whose nonzero tag matches the
//                     current cdb_tag reports ready=1 in the broadcast cycle.
//
// Ports:
//   clock             rising-edge clock
//   reset             asynchronous active-low reset, clears all rows
//   rs1_idx/rs2_idx   source architectural indices from decode
//   rename_en         dispatch this cycle
//   dest_idx          destination architectural index
//   rob_entry         ROB tag of the dispatched instruction (never 0)
//   cdb_tag           completing tag, 0 = no broadcast
//   retire_en         ROB head commits
//   retire_idx        committed architectural destination
//   retire_tag        committed ROB tag
//   squash            flush all mappings
//   mt2rs_packet_out  {rs1_tag, rs2_tag, rs1_ready, rs2_ready}

module map_table
    import map_table_pkg::*;
#(
    parameter int unsigned NUM_ARCH_REG = map_table_pkg::NUM_ARCH_REG,
    parameter int unsigned TAG_W        = map_table_pkg::TAG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        rs1_idx,
    input  logic [4:0]        rs2_idx,
    input  logic              rename_en,
    input  logic [4:0]        dest_idx,
    input  logic [TAG_W-1:0]  rob_entry,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic              retire_en,
    input  logic [4:0]        retire_idx,
    input  logic [TAG_W-1:0]  retire_tag,
    input  logic              squash,
    output MT2RS_PACKET       mt2rs_packet_out
);

    logic [TAG_W-1:0] tag_q [NUM_ARCH_REG];
    logic             rdy_q [NUM_ARCH_REG];
    logic [TAG_W-1:0] tag_d [NUM_ARCH_REG];
    logic             rdy_d [NUM_ARCH_REG];

    // ------------------------------------------------------------------
    // Next-state: one priority chain per row.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_ARCH_REG; i++) begin
            tag_d[i] = tag_q[i];
            rdy_d[i] = rdy_q[i];
            if (i == 0) begin
                tag_d[i] = '0;
                rdy_d[i] = 1'b0;
            end else if (squash) begin
                tag_d[i] = '0;
                rdy_d[i] = 1'b0;
            end else if (rename_en && (32'(dest_idx) == 32'(i))) begin
                // New producer; any CDB hit this cycle belongs to the old tag.
                tag_d[i] = rob_entry;
                rdy_d[i] = 1'b0;
            end else if (retire_en && (32'(retire_idx) == 32'(i)) &&
                         (tag_q[i] == retire_tag)) begin
                // Only clear if the row still names the retiring tag; a newer
                // rename of the same register must survive.
                tag_d[i] = '0;
                rdy_d[i] = 1'b0;
            end else if (mt_tag_hit(tag_q[i], cdb_tag)) begin
                rdy_d[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH_REG; i++) begin
                tag_q[i] <= '0;
                rdy_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ARCH_REG; i++) begin
                tag_q[i] <= tag_d[i];
                rdy_q[i] <= rdy_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Source lookup from pre-edge state.
    // ------------------------------------------------------------------
    logic [TAG_W-1:0] rs1_tag;
    logic [TAG_W-1:0] rs2_tag;
    logic             rs1_rdy_raw;
    logic             rs2_rdy_raw;
    logic             rs1_byp;
    logic             rs2_byp;

    always_comb begin
        rs1_tag     = '0;
        rs1_rdy_raw = 1'b0;
        rs2_tag     = '0;
        rs2_rdy_raw = 1'b0;
        if (32'(rs1_idx) < NUM_ARCH_REG) begin
            rs1_tag     = tag_q[rs1_idx];
            rs1_rdy_raw = rdy_q[rs1_idx];
        end
        if (32'(rs2_idx) < NUM_ARCH_REG) begin
            rs2_tag     = tag_q[rs2_idx];
            rs2_rdy_raw = rdy_q[rs2_idx];
        end
    end

`ifdef MT_CDB_BYPASS_EN
    always_comb begin
        rs1_byp = mt_tag_hit(rs1_tag, cdb_tag);
        rs2_byp = mt_tag_hit(rs2_tag, cdb_tag);
    end
`else
    // The RS entry snoops the CDB itself; the table reports ready a cycle late.
    always_comb begin
        rs1_byp = 1'b0;
        rs2_byp = 1'b0;
    end
`endif

    always_comb begin
        mt2rs_packet_out.rs1_tag   = rs1_tag;
        mt2rs_packet_out.rs2_tag   = rs2_tag;
        // Tag 0 always reads as not-ready so the RS takes the register file.
        mt2rs_packet_out.rs1_ready = (rs1_tag != '0) && (rs1_rdy_raw || rs1_byp);
        mt2rs_packet_out.rs2_ready = (rs2_tag != '0) && (rs2_rdy_raw || rs2_byp);
    end

endmodule

// File: tb/tb_map_table.sv
// tb_map_table -- self-checking bench for map_table.
// Directed scenarios push fixed expected packets; a random phase pushes
// expectations from a behavioural table model. Each expectation is queued
// when stimulus is driven and popped when the outputs are sampled.

module tb_map_table;
    import map_table_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  rs1_idx, rs2_idx, dest_idx, retire_idx;
    logic        rename_en, retire_en, squash;
    logic [3:0]  rob_entry, cdb_tag, retire_tag;
    MT2RS_PACKET mt2rs_packet_out;

    map_table dut (
        .clock            (clock),
        .reset            (reset),
        .rs1_idx          (rs1_idx),
        .rs2_idx          (rs2_idx),
        .rename_en        (rename_en),
        .dest_idx         (dest_idx),
        .rob_entry        (rob_entry),
        .cdb_tag          (cdb_tag),
        .retire_en        (retire_en),
        .retire_idx       (retire_idx),
        .retire_tag       (retire_tag),
        .squash           (squash),
        .mt2rs_packet_out (mt2rs_packet_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        MT2RS_PACKET exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [3:0]  m_tag [32];
    logic        m_rdy [32];

    task automatic check_val(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic MT2RS_PACKET mk(input logic [3:0] t1, input logic k1,
                                       input logic [3:0] t2, input logic k2);
        MT2RS_PACKET p;
        p.rs1_tag   = t1;
        p.rs1_ready = k1;
        p.rs2_tag   = t2;
        p.rs2_ready = k2;
        return p;
    endfunction

    function automatic logic model_ready(input logic [4:0] idx);
        logic r;
        r = m_rdy[idx];
`ifdef MT_CDB_BYPASS_EN
        if (cdb_tag != 4'd0 && cdb_tag == m_tag[idx]) r = 1'b1;
`endif
        return (m_tag[idx] != 4'd0) && r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_tag[i] = 4'd0;
            m_rdy[i] = 1'b0;
        end
    endtask

    // Applies the behaviour of one clock edge to the model.
    task automatic model_update();
        logic [3:0] nt [32];
        logic       nr [32];
        if (!reset) begin
            model_clear();
            return;
        end
        for (int i = 0; i < 32; i++) begin
            nt[i] = m_tag[i];
            nr[i] = m_rdy[i];
            if (i != 0) begin
                if (squash) begin
                    nt[i] = 4'd0; nr[i] = 1'b0;
                end else if (rename_en && dest_idx == 5'(i)) begin
                    nt[i] = rob_entry; nr[i] = 1'b0;
                end else if (retire_en && retire_idx == 5'(i) && m_tag[i] == retire_tag) begin
                    nt[i] = 4'd0; nr[i] = 1'b0;
                end else if (cdb_tag != 4'd0 && m_tag[i] == cdb_tag) begin
                    nr[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 32; i++) begin
            m_tag[i] = nt[i];
            m_rdy[i] = nr[i];
        end
    endtask

    task automatic idle();
        rename_en  = 1'b0; dest_idx   = 5'd0; rob_entry  = 4'd0;
        cdb_tag    = 4'd0; retire_en  = 1'b0; retire_idx = 5'd0;
        retire_tag = 4'd0; squash     = 1'b0;
    endtask

    task automatic set_rs(input logic [4:0] a, input logic [4:0] b);
        rs1_idx = a;
        rs2_idx = b;
    endtask

    task automatic rename(input logic [4:0] d, input logic [3:0] t);
        rename_en = 1'b1; dest_idx = d; rob_entry = t;
    endtask

    task automatic retire(input logic [4:0] d, input logic [3:0] t);
        retire_en = 1'b1; retire_idx = d; retire_tag = t;
    endtask

    task automatic push_exp(input string name, input MT2RS_PACKET p);
        sb_item_t it;
        it.name = name;
        it.exp  = p;
        sb_q.push_back(it);
    endtask

    task automatic push_model(input string name);
        push_exp(name, mk(m_tag[rs1_idx], model_ready(rs1_idx),
                          m_tag[rs2_idx], model_ready(rs2_idx)));
    endtask

    task automatic compare_all(input int dly);
        sb_item_t it;
        #(dly);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.name, 32'(mt2rs_packet_out), 32'(it.exp));
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic tick();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    initial begin
        model_clear();
        idle();
        set_rs(5'd0, 5'd0);
        repeat (2) @(negedge clock);

        // Reset state, with active inputs that must be ignored.
        set_rs(5'd5, 5'd9);
        rename(5'd5, 4'd3);
        push_exp("reset_rows", mk(4'd0, 1'b0, 4'd0, 1'b0));
        compare_all(2);
        tick();
        reset = 1'b1;
        idle();
        push_exp("reset_ignored_inputs", mk(4'd0, 1'b0, 4'd0, 1'b0));
        compare_all(2);
        tick();

        // Rename r3 -> 2; same-cycle lookup sees the old mapping.
        rename(5'd3, 4'd2);
        set_rs(5'd3, 5'd3);
        push_exp("rename_same_cycle", mk(4'd0, 1'b0, 4'd0, 1'b0));
        compare_all(2);
        tick();
        idle();
        push_exp("rename_next_cycle", mk(4'd2, 1'b0, 4'd2, 1'b0));
        compare_all(2);
        tick();

        // CDB broadcast of tag 2.
        cdb_tag = 4'd2;
        set_rs(5'd3, 5'd0);
`ifdef MT_CDB_BYPASS_EN
        push_exp("cdb_broadcast_cycle", mk(4'd2, 1'b1, 4'd0, 1'b0));
`else
        push_exp("cdb_broadcast_cycle", mk(4'd2, 1'b0, 4'd0, 1'b0));
`endif
        compare_all(2);
        tick();
        idle();
        push_exp("cdb_next_cycle", mk(4'd2, 1'b1, 4'd0, 1'b0));
        compare_all(2);
        tick();

        // Retire of a stale tag must not clear a re-renamed row.
        rename(5'd4, 4'd3);
        tick();
        rename(5'd4, 4'd5);
        tick();
        idle();
        retire(5'd4, 4'd3);
        set_rs(5'd4, 5'd3);
        push_exp("retire_stale_cycle", mk(4'd5, 1'b0, 4'd2, 1'b1));
        compare_all(2);
        tick();
        idle();
        push_exp("retire_stale_kept", mk(4'd5, 1'b0, 4'd2, 1'b1));
        compare_all(2);
        retire(5'd4, 4'd5);
        tick();
        idle();
        push_exp("retire_match_clears", mk(4'd0, 1'b0, 4'd2, 1'b1));
        compare_all(2);

        // Rename beats retire on the same row.
        rename(5'd6, 4'd1);
        tick();
        idle();
        rename(5'd6, 4'd7);
        retire(5'd6, 4'd1);
        tick();
        idle();
        set_rs(5'd6, 5'd0);
        push_exp("rename_beats_retire", mk(4'd7, 1'b0, 4'd0, 1'b0));
        compare_all(2);

        // Rename beats CDB on the same row.
        rename(5'd1, 4'd4);
        cdb_tag = 4'd4;
        set_rs(5'd1, 5'd6);
        push_exp("rename_cdb_cycle", mk(4'd0, 1'b0, 4'd7, 1'b0));
        compare_all(2);
        tick();
        idle();
        push_exp("rename_beats_cdb", mk(4'd4, 1'b0, 4'd7, 1'b0));
        compare_all(2);

        // Retire beats CDB on the same row.
        retire(5'd1, 4'd4);
        cdb_tag = 4'd4;
        tick();
        idle();
        push_exp("retire_beats_cdb", mk(4'd0, 1'b0, 4'd7, 1'b0));
        compare_all(2);

        // Register 0 is never renamed.
        rename(5'd0, 4'd9);
        set_rs(5'd0, 5'd0);
        tick();
        idle();
        push_exp("r0_not_renamed", mk(4'd0, 1'b0, 4'd0, 1'b0));
        compare_all(2);

        // Asynchronous reset mid-cycle with r5 mapped.
        rename(5'd5, 4'd1);
        tick();
        idle();
        set_rs(5'd5, 5'd3);
        push_exp("pre_reset_mapped", mk(4'd1, 1'b0, 4'd2, 1'b1));
        compare_all(1);
        reset = 1'b0;
        push_exp("reset_async_clear", mk(4'd0, 1'b0, 4'd0, 1'b0));
        compare_all(1);
        rename(5'd5, 4'd2);
        tick();
        push_exp("reset_held", mk(4'd0, 1'b0, 4'd0, 1'b0));
        compare_all(1);
        reset = 1'b1;
        idle();
        set_rs(5'd5, 5'd5);
        push_exp("after_reset_r5", mk(4'd0, 1'b0, 4'd0, 1'b0));
        compare_all(1);
        tick();

        // Squash overrides a same-cycle rename.
        rename(5'd1, 4'd1); tick();
        rename(5'd2, 4'd2); tick();
        rename(5'd3, 4'd3); tick();
        idle();
        set_rs(5'd1, 5'd3);
        push_exp("squash_pre_map", mk(4'd1, 1'b0, 4'd3, 1'b0));
        compare_all(2);
        squash = 1'b1;
        rename(5'd7, 4'd6);
        tick();
        idle();
        for (int i = 0; i < 32; i++) begin
            set_rs(5'(i), 5'(31 - i));
            push_exp($sformatf("squash_row%0d", i), mk(4'd0, 1'b0, 4'd0, 1'b0));
            compare_all(1);
        end

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            idle();
            set_rs(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) rename(5'($urandom_range(0, 31)),
                                                  4'($urandom_range(1, 15)));
            if ($urandom_range(0, 2) == 0) cdb_tag = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) begin
                retire_en  = 1'b1;
                retire_idx = 5'($urandom_range(0, 31));
                retire_tag = ($urandom_range(0, 1) == 1) ? m_tag[retire_idx]
                                                         : 4'($urandom_range(0, 15));
            end
            squash = ($urandom_range(0, 29) == 0);
            push_model("random");
            compare_all(2);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
